// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the EX stage and muldiv_unit.
//   master (pipeline side): drives START, SELECT, DATA1, DATA2, FLUSH;
//                           observes BUSY, DONE, RESULT, DIV_BY_ZERO.
//   slave  (unit side)    : the mirror image of master.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             START;
  logic [2:0]       SELECT;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic             FLUSH;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic             DIV_BY_ZERO;

  modport master (
    output START, SELECT, DATA1, DATA2, FLUSH,
    input  BUSY, DONE, RESULT, DIV_BY_ZERO
  );

  modport slave (
    input  START, SELECT, DATA1, DATA2, FLUSH,
    output BUSY, DONE, RESULT, DIV_BY_ZERO
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit. Radix-2 shift-add multiply
// and restoring divide, one bit per cycle, on operand magnitudes; signs are
// applied in FIXUP.
// Ports:
//   CLK   - rising-edge clock
//   RESET - synchronous, active-high reset
//   bus   - muldiv_unit_if.slave: START/SELECT(funct3)/DATA1/DATA2/FLUSH in,
//           BUSY/DONE/RESULT/DIV_BY_ZERO out (all registered).
// Build option: define MULDIV_FAST_MUL_EN to compute multiplies with a
// single-cycle extended multiplier (IDLE -> FIXUP); divides stay iterative.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1  // derived; leave at default
) (
  input  logic         CLK,
  input  logic         RESET,
  muldiv_unit_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, OUT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic             neg_a_q, neg_b_q, special_q, dbz_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor magnitude
  logic [PW-1:0]    acc_q;    // mul: {hi, lo/multiplier}; div: {remainder, quotient/dividend}
  logic [WIDTH-1:0] res_q;    // result staged for commit in OUT
  logic             busy_q, done_q, dbz_out_q;
  logic [WIDTH-1:0] result_q;

  logic             sgn_a_c, sgn_b_c, neg_a_c, neg_b_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c, special_res_c;
  logic             div_zero_c, div_ovf_c, special_c, fast_c, accept_c;
  logic [WIDTH:0]   mul_sum_c, div_part_c, div_diff_c;
  logic [PW-1:0]    mul_step_c, div_step_c, prod_c;
  logic [WIDTH-1:0] quo_c, rem_c, fix_c;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_c = ~bus.SELECT[2];
`else
  assign fast_c = 1'b0;
`endif

  // Decode of the live request; only consumed on the accept edge.
  always_comb begin
    sgn_a_c = 1'b0;
    sgn_b_c = 1'b0;
    case (bus.SELECT)
      3'b001, 3'b100, 3'b110: begin
        sgn_a_c = 1'b1;
        sgn_b_c = 1'b1;
      end
      3'b010:  sgn_a_c = 1'b1;
      default: ;
    endcase
    neg_a_c    = sgn_a_c & bus.DATA1[WIDTH-1];
    neg_b_c    = sgn_b_c & bus.DATA2[WIDTH-1];
    abs_a_c    = neg_a_c ? -bus.DATA1 : bus.DATA1;
    abs_b_c    = neg_b_c ? -bus.DATA2 : bus.DATA2;
    div_zero_c = (bus.DATA2 == '0);
    // Most-negative / -1 only overflows for the signed ops (DIV, REM: funct3[0]=0).
    div_ovf_c  = ~bus.SELECT[0] & (bus.DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) &
                 (bus.DATA2 == '1);
    special_c  = bus.SELECT[2] & (div_zero_c | div_ovf_c);
    special_res_c = '0;
    if (div_zero_c) special_res_c = bus.SELECT[1] ? bus.DATA1 : '1;
    else            special_res_c = bus.SELECT[1] ? '0 : bus.DATA1;
  end

  // One multiply or divide iteration on the accumulator.
  always_comb begin
    mul_sum_c = {1'b0, acc_q[PW-1:WIDTH]};
    if (acc_q[0]) mul_sum_c = mul_sum_c + {1'b0, opnd_q};
    mul_step_c = {mul_sum_c, acc_q[WIDTH-1:1]};

    div_part_c = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_c = div_part_c - {1'b0, opnd_q};
    // Negative difference shows up as the top bit: restore, shift in 0.
    if (div_diff_c[WIDTH]) div_step_c = {div_part_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else                   div_step_c = {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Sign application and half selection.
  always_comb begin
    prod_c = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_c  = acc_q[WIDTH-1:0];
    rem_c  = acc_q[PW-1:WIDTH];
    case (op_q)
      3'b000:                 fix_c = prod_c[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_c = prod_c[PW-1:WIDTH];
      3'b100, 3'b101:         fix_c = (neg_a_q ^ neg_b_q) ? -quo_c : quo_c;
      default:                fix_c = neg_a_q ? -rem_c : rem_c;
    endcase
  end

  // Next-state logic; FLUSH returns any busy state to IDLE.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: if (bus.START && !bus.FLUSH) begin
        accept_c = 1'b1;
        state_d  = (special_c || fast_c) ? FIXUP : CALC;
      end
      CALC:    if (cnt_q == CNT_W'(1)) state_d = FIXUP;
      FIXUP:   state_d = OUT;
      default: state_d = IDLE;
    endcase
    if (bus.FLUSH) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and registered outputs. The commit edge is the one leaving OUT,
  // so RESULT, DIV_BY_ZERO and DONE all change together and FLUSH in OUT
  // cannot cancel them.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q      <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      special_q <= 1'b0;
      dbz_q     <= 1'b0;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      result_q  <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_q == OUT);
      if (state_q == OUT) begin
        result_q  <= res_q;
        dbz_out_q <= dbz_q;
      end
      case (state_q)
        IDLE: if (accept_c) begin
          op_q      <= bus.SELECT;
          neg_a_q   <= neg_a_c;
          neg_b_q   <= neg_b_c;
          special_q <= special_c;
          dbz_q     <= bus.SELECT[2] & div_zero_c;
          cnt_q     <= CNT_W'(WIDTH);
          res_q     <= special_res_c;
          opnd_q    <= bus.SELECT[2] ? abs_b_c : abs_a_c;
          if (fast_c) acc_q <= PW'(abs_a_c) * PW'(abs_b_c);
          else        acc_q <= {{WIDTH{1'b0}}, (bus.SELECT[2] ? abs_a_c : abs_b_c)};
        end
        CALC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          acc_q <= op_q[2] ? div_step_c : mul_step_c;
        end
        FIXUP: if (!special_q) res_q <= fix_c;
        default: ;
      endcase
    end
  end

  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.RESULT      = result_q;
  assign bus.DIV_BY_ZERO = dbz_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit (WIDTH=32) against
// an arithmetic reference model.
module tb_muldiv_unit;
  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] last_res;
  logic        last_dbz;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (sel)
      3'd0: begin p = 64'(ua * ub); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a;
            else return 32'($signed(a) / $signed(b));
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'h0;
            else return 32'($signed(a) % $signed(b));
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] sel, input logic [31:0] a,
                                 input logic [31:0] b);
    if (sel[2] && (b == 0 || (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 2;
    if (!sel[2] && FAST) return 2;
    return int'(W) + 2;
  endfunction

  // One operation: START sampled at edge 0, BUSY/DONE checked after every edge
  // up to the DONE cycle, then RESULT and DIV_BY_ZERO.
  task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input bit poke);
    int   lat;
    logic exp_dbz;
    lat     = ref_lat(sel, a, b);
    exp_dbz = sel[2] && (b == 0);
    bus.START  = 1'b1;
    bus.SELECT = sel;
    bus.DATA1  = a;
    bus.DATA2  = b;
    @(posedge clk); #1;
    bus.START  = 1'b0;
    bus.SELECT = 3'($urandom);
    bus.DATA1  = $urandom;
    bus.DATA2  = $urandom;
    check($sformatf("status_e0 sel=%0d", sel), {bus.BUSY, bus.DONE}, 2'b10);
    for (int k = 1; k <= lat; k++) begin
      if (poke && k == 5) begin
        bus.START  = 1'b1;
        bus.SELECT = 3'b101;
        bus.DATA2  = 32'h0;
      end
      @(posedge clk); #1;
      if (poke && k == 5) bus.START = 1'b0;
      check($sformatf("status_e%0d sel=%0d", k, sel), {bus.BUSY, bus.DONE}, {k < lat, k == lat});
    end
    check($sformatf("result sel=%0d a=%0h b=%0h", sel, a, b), bus.RESULT, exp_r);
    check($sformatf("dbz sel=%0d b=%0h", sel, b), bus.DIV_BY_ZERO, exp_dbz);
    last_res = exp_r;
    last_dbz = exp_dbz;
  endtask

  initial begin
    logic [2:0]  s;
    logic [31:0] a, b;
    bit          seen;
    int          d1, d2;

    rst = 1'b1;
    bus.START = 1'b0; bus.FLUSH = 1'b0; bus.SELECT = 3'd0; bus.DATA1 = '0; bus.DATA2 = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_status", {bus.BUSY, bus.DONE, bus.DIV_BY_ZERO}, 3'b000);
    check("reset_result", bus.RESULT, 32'h0);
    rst = 1'b0;
    last_res = '0;
    last_dbz = 1'b0;

    // Directed values with hand-computed results.
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b1);
    run_op(3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 1'b0);
    run_op(3'd5, 32'd100,        32'd7,         32'd14,        1'b0);
    run_op(3'd7, 32'd100,        32'd7,         32'd2,         1'b0);
    run_op(3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b0);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(3'd7, 32'h1234_5678,  32'd0,         32'h1234_5678, 1'b0);
    run_op(3'd0, 32'd7,          32'd3,         32'd21,        1'b0);

    // Random operations against the model, biased toward the corner operands.
    for (int i = 0; i < 30; i++) begin
      s = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        default: ;
      endcase
      run_op(s, a, b, ref_res(s, a, b), 1'b0);
    end

    // FLUSH at edge 10 of an iterative DIV.
    bus.START = 1'b1; bus.SELECT = 3'd4; bus.DATA1 = 32'd1000; bus.DATA2 = 32'd9;
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.FLUSH = 1'b1;
    @(posedge clk); #1;
    bus.FLUSH = 1'b0;
    check("flush_status", {bus.BUSY, bus.DONE}, 2'b00);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.DONE) seen = 1'b1;
    end
    check("flush_no_done", seen, 1'b0);
    check("flush_result_kept", bus.RESULT, last_res);
    check("flush_dbz_kept", bus.DIV_BY_ZERO, last_dbz);

    // FLUSH and START together in IDLE: the request is dropped.
    bus.START = 1'b1; bus.FLUSH = 1'b1; bus.SELECT = 3'd5; bus.DATA2 = 32'd0;
    @(posedge clk); #1;
    bus.START = 1'b0; bus.FLUSH = 1'b0;
    check("flush_start_drop", bus.BUSY, 1'b0);

    // Back-to-back: START held through a DIVU, then a MUL follows immediately.
    bus.START = 1'b1; bus.SELECT = 3'd5; bus.DATA1 = 32'd100; bus.DATA2 = 32'd7;
    @(posedge clk); #1;
    bus.SELECT = 3'd0; bus.DATA1 = 32'd7; bus.DATA2 = 32'd3;
    d1 = -1;
    d2 = -1;
    for (int k = 1; k <= 150 && d2 < 0; k++) begin
      @(posedge clk); #1;
      if (d1 > 0 && k == d1 + 1) bus.START = 1'b0;
      if (bus.DONE) begin
        if (d1 < 0) begin
          d1 = k;
          check("b2b_first_result", bus.RESULT, 32'd14);
        end else begin
          d2 = k;
          check("b2b_second_result", bus.RESULT, 32'd21);
        end
      end
    end
    bus.START = 1'b0;
    check("b2b_first_done_edge", 64'(d1), 64'(int'(W) + 2));
    check("b2b_done_gap", 64'(d2 - d1), 64'(ref_lat(3'd0, 32'd7, 32'd3) + 1));
    last_res = 32'd21;

    // RESET at edge 20 of a MULHU.
    bus.START = 1'b1; bus.SELECT = 3'd3; bus.DATA1 = 32'hDEAD_BEEF; bus.DATA2 = 32'h1234_5678;
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_mid_status", {bus.BUSY, bus.DONE, bus.DIV_BY_ZERO}, 3'b000);
    check("reset_mid_result", bus.RESULT, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.DONE || bus.BUSY) seen = 1'b1;
    end
    check("reset_no_done", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
